// File: rtl/rdata_packetizer_pkg.sv
// Shared constants for the read-data packetizer.
//   DATA_WIDTH  : default read beat width
//   KEEP_WIDTH  : AXIS byte-enable width for the default beat
//   CNT_WIDTH   : default outstanding-read counter width
//   ENTRY_WIDTH : width of one buffered entry {last, data} for the default beat
//   entry_width : the same {last, data} width for any beat width
package rdata_pkt_pkg;

  localparam int DATA_WIDTH  = 512;
  localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH   = 16;
  localparam int ENTRY_WIDTH = DATA_WIDTH + 1;

  // Buffered entries carry the packet-end tag above the data bits.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/rdata_packetizer_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wr_data; honoured when not full, or when full with a same-cycle pop
//   wr_data  : entry to write
//   pop      : consume the head entry; ignored when empty
//   rd_data  : head entry, valid while !empty (driven to zero when empty)
//   level    : registered occupancy, 0..DEPTH
//   full     : level == DEPTH
//   empty    : level == 0
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // The head slot is never overwritten while it is visible: a write only lands
  // on rd_ptr when the FIFO is empty, or when full and that entry is popping.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/rdata_packetizer.sv
// Frames DDR4 read-data returns into AXIS packets.
//   clk, rst        : c0_ddr4_clk, synchronous active-high reset
//   ddr_read        : per-slot read-issue strobes (same cycle as issue)
//   rd_data(_en)    : returned beat; cannot be back-pressured
//   m_axis_*        : AXIS master; tlast on the beat that drains all outstanding
//                     reads, or after MAX_PKT_BEATS beats in one packet
//   clr_err         : pulse clearing the sticky errors and drop_cnt
//   outstanding     : reads issued but not yet returned (saturating)
//   buf_level       : beats held in the local buffer
//   err_overflow    : sticky, a beat was dropped because the buffer was full
//   err_underflow   : sticky, a beat arrived with no read outstanding
//   err_cnt_sat     : sticky, the outstanding counter clamped at its maximum
//   drop_cnt        : number of dropped beats (saturating)
module rdata_packetizer #(
  parameter int DATA_WIDTH    = rdata_pkt_pkg::DATA_WIDTH,
  parameter int SLOTS         = 4,
  parameter int CNT_WIDTH     = rdata_pkt_pkg::CNT_WIDTH,
  parameter int BUF_DEPTH     = 16,
  parameter int MAX_PKT_BEATS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SLOTS-1:0]             ddr_read,
  input  logic [DATA_WIDTH-1:0]        rd_data,
  input  logic                         rd_data_en,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic                         clr_err,
  output logic [CNT_WIDTH-1:0]         outstanding,
  output logic [$clog2(BUF_DEPTH):0]   buf_level,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic                         err_cnt_sat,
  output logic [15:0]                  drop_cnt
);

  import rdata_pkt_pkg::entry_width;

  localparam int ENTRY_W = entry_width(DATA_WIDTH);
  // Three guard bits hold outstanding + popcount without wrapping.
  localparam int AW      = CNT_WIDTH + 3;
  localparam int IDX_W   = (MAX_PKT_BEATS > 1) ? $clog2(MAX_PKT_BEATS) : 1;
  localparam logic [AW-1:0]    CNT_MAX_A = {3'b000, {CNT_WIDTH{1'b1}}};
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MAX_PKT_BEATS - 1);

  logic [CNT_WIDTH-1:0] outstanding_reg, outstanding_next;
  logic [IDX_W-1:0]     beat_idx_reg, beat_idx_next;
  logic                 err_overflow_reg, err_underflow_reg, err_cnt_sat_reg;
  logic [15:0]          drop_cnt_reg;

  logic [SLOTS:0][AW-1:0] pc_sum;
  logic [AW-1:0]          avail;
  logic [AW-1:0]          remaining;
  logic                   underflow_evt;
  logic                   sat_evt;
  logic                   drop_evt;
  logic                   beat_last;
  logic                   push;
  logic                   pop;

  logic [ENTRY_W-1:0]           fifo_wr_entry;
  logic [ENTRY_W-1:0]           fifo_rd_entry;
  logic [$clog2(BUF_DEPTH):0]   fifo_level;
  logic                         fifo_full;
  logic                         fifo_empty;

  // Popcount of the issue strobes as a running prefix sum.
  assign pc_sum[0] = '0;
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_popcount
    assign pc_sum[gi+1] = pc_sum[gi] + {{(AW-1){1'b0}}, ddr_read[gi]};
  end

  always_comb begin
    // Same-cycle issues are counted before the return decrements, so a return
    // that coincides with a new read never closes the packet early.
    avail         = {3'b000, outstanding_reg} + pc_sum[SLOTS];
    underflow_evt = rd_data_en && (avail == '0);
    remaining     = avail;
    if (rd_data_en) begin
      remaining = (avail == '0) ? '0 : avail - AW'(1);
    end
    sat_evt          = (remaining > CNT_MAX_A);
    outstanding_next = sat_evt ? {CNT_WIDTH{1'b1}} : remaining[CNT_WIDTH-1:0];

    // An underflow beat has avail == 0 and is therefore tagged last as well.
    beat_last = (avail <= AW'(1)) || (beat_idx_reg == IDX_LAST);

    pop      = !fifo_empty && m_axis_tready;
    push     = rd_data_en && (!fifo_full || pop);
    drop_evt = rd_data_en && fifo_full && !pop;

    // Dropped beats never reach the buffer, so they do not count toward the packet.
    beat_idx_next = beat_idx_reg;
    if (push) begin
      beat_idx_next = beat_last ? '0 : beat_idx_reg + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_reg <= '0;
      beat_idx_reg    <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      beat_idx_reg    <= beat_idx_next;
    end
  end

  // Clear wins over a same-cycle error so the pulse always leaves a clean slate.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
      err_cnt_sat_reg   <= 1'b0;
      drop_cnt_reg      <= '0;
    end else if (clr_err) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
      err_cnt_sat_reg   <= 1'b0;
      drop_cnt_reg      <= '0;
    end else begin
      err_overflow_reg  <= err_overflow_reg  | drop_evt;
      err_underflow_reg <= err_underflow_reg | underflow_evt;
      err_cnt_sat_reg   <= err_cnt_sat_reg   | sat_evt;
      if (drop_evt && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  assign fifo_wr_entry = {beat_last, rd_data};

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (fifo_wr_entry),
    .pop     (pop),
    .rd_data (fifo_rd_entry),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tdata  = fifo_rd_entry[DATA_WIDTH-1:0];
  assign m_axis_tlast  = fifo_rd_entry[DATA_WIDTH];
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tkeep  = '1;

  assign outstanding   = outstanding_reg;
  assign buf_level     = fifo_level;
  assign err_overflow  = err_overflow_reg;
  assign err_underflow = err_underflow_reg;
  assign err_cnt_sat   = err_cnt_sat_reg;
  assign drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_rdata_packetizer.sv
module tb_rdata_packetizer;

  localparam int DW  = 64;
  localparam int SL  = 4;
  localparam int CW  = 16;
  localparam int BD  = 16;
  localparam int MPB = 4;
  localparam int LW  = $clog2(BD) + 1;
  localparam int CNT_MAX = 65535;

  logic            clk = 1'b0;
  logic            rst;
  logic [SL-1:0]   ddr_read;
  logic [DW-1:0]   rd_data;
  logic            rd_data_en;
  logic [DW-1:0]   m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            clr_err;
  logic [CW-1:0]   outstanding;
  logic [LW-1:0]   buf_level;
  logic            err_overflow;
  logic            err_underflow;
  logic            err_cnt_sat;
  logic [15:0]     drop_cnt;

  always #5 clk = ~clk;

  rdata_packetizer #(
    .DATA_WIDTH    (DW),
    .SLOTS         (SL),
    .CNT_WIDTH     (CW),
    .BUF_DEPTH     (BD),
    .MAX_PKT_BEATS (MPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ddr_read      (ddr_read),
    .rd_data       (rd_data),
    .rd_data_en    (rd_data_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .clr_err       (clr_err),
    .outstanding   (outstanding),
    .buf_level     (buf_level),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_cnt_sat   (err_cnt_sat),
    .drop_cnt      (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard of {tlast, tdata} in the order the AXIS side must present them.
  logic [DW:0] exp_q[$];

  // Reference model: plain integer bookkeeping of the packetizer rules.
  int   m_out;
  int   m_level;
  int   m_pkt_beats;
  bit   m_ovf, m_udf, m_sat;
  int   m_drop;
  logic tready_cur;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every AXIS handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat actual=%0h required=none", {m_axis_tlast, m_axis_tdata});
      end else begin
        e = exp_q.pop_front();
        $display("beat data=%h last=%b", m_axis_tdata, m_axis_tlast);
        check("beat", {m_axis_tlast, m_axis_tdata}, e);
      end
    end
  end

  task automatic model_clear();
    m_out = 0; m_level = 0; m_pkt_beats = 0;
    m_ovf = 0; m_udf = 0; m_sat = 0; m_drop = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs, advance the model, then compare status.
  task automatic step(input logic [SL-1:0] rd, input logic en, input logic [DW-1:0] d,
                      input logic clr);
    int  avail, nxt;
    bit  pop, full, last, accept, drop, under, sat;
    bit  held;
    logic [DW:0] prior;
    ddr_read      = rd;
    rd_data_en    = en;
    rd_data       = d;
    clr_err       = clr;
    m_axis_tready = tready_cur;
    #1;
    held  = m_axis_tvalid && !m_axis_tready;
    prior = {m_axis_tlast, m_axis_tdata};

    avail  = m_out + $countones(rd);
    pop    = (m_level > 0) && tready_cur;
    full   = (m_level == BD);
    under  = en && (avail == 0);
    nxt    = en ? ((avail == 0) ? 0 : avail - 1) : avail;
    sat    = (nxt > CNT_MAX);
    if (sat) nxt = CNT_MAX;
    last   = (avail <= 1) || (m_pkt_beats == MPB - 1);
    accept = en && (!full || pop);
    drop   = en && full && !pop;
    if (pop) m_level--;
    if (accept) begin
      m_level++;
      exp_q.push_back({last, d});
      m_pkt_beats = last ? 0 : m_pkt_beats + 1;
    end
    if (clr) begin
      m_ovf = 0; m_udf = 0; m_sat = 0; m_drop = 0;
    end else begin
      if (drop)  m_ovf = 1;
      if (under) m_udf = 1;
      if (sat)   m_sat = 1;
      if (drop && m_drop < 65535) m_drop++;
    end
    m_out = nxt;

    @(posedge clk);
    #1;
    ddr_read   = '0;
    rd_data_en = 1'b0;
    clr_err    = 1'b0;
    check("outstanding",   outstanding, m_out);
    check("buf_level",     buf_level, m_level);
    check("tvalid",        m_axis_tvalid, (m_level > 0));
    check("err_overflow",  err_overflow, m_ovf);
    check("err_underflow", err_underflow, m_udf);
    check("err_cnt_sat",   err_cnt_sat, m_sat);
    check("drop_cnt",      drop_cnt, m_drop);
    if (held) check("hold_stable", {m_axis_tlast, m_axis_tdata}, prior);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, '0, 1'b0);
  endtask

  task automatic beat(input logic [SL-1:0] rd);
    step(rd, 1'b1, {$urandom, $urandom}, 1'b0);
  endtask

  task automatic do_reset();
    tready_cur    = 1'b0;
    m_axis_tready = 1'b0;
    ddr_read      = '0;
    rd_data_en    = 1'b0;
    rd_data       = '0;
    clr_err       = 1'b0;
    rst           = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    check("rst_tvalid",      m_axis_tvalid, 1'b0);
    check("rst_buf_level",   buf_level, 0);
    check("rst_outstanding", outstanding, 0);
    @(posedge clk);
    #1;
    check("rst_tdata",  m_axis_tdata, 0);
    check("rst_tlast",  m_axis_tlast, 1'b0);
    check("rst_tkeep",  m_axis_tkeep, 8'hFF);
    check("rst_errors", {err_overflow, err_underflow, err_cnt_sat}, 3'b000);
    check("rst_drop",   drop_cnt, 0);
    rst        = 1'b0;
    tready_cur = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] a;
    rst = 1'b1;
    do_reset();

    // Single read, returned 20 cycles later.
    a = 64'hA5A5_0001_DEAD_BEEF;
    step(4'b0001, 1'b0, '0, 1'b0);
    idle(19);
    step(4'b0000, 1'b1, a, 1'b0);
    check("single_tvalid", m_axis_tvalid, 1'b1);
    check("single_tlast",  m_axis_tlast, 1'b1);
    check("single_tdata",  m_axis_tdata, a);
    check("single_outstanding", outstanding, 0);
    idle(3);

    // Burst of four reads, four back-to-back returns.
    step(4'b1111, 1'b0, '0, 1'b0);
    check("burst_outstanding", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      beat('0);
      check("burst_outstanding", outstanding, 3 - i);
    end
    idle(3);

    // Overlap: last return coincides with a new issue.
    step(4'b0011, 1'b0, '0, 1'b0);
    beat('0);
    beat(4'b0001);
    beat('0);
    idle(4);

    // Backpressure and overflow.
    tready_cur = 1'b0;
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) beat('0);
    check("ovf_level", buf_level, 16);
    check("ovf_flag",  err_overflow, 1'b1);
    check("ovf_drops", drop_cnt, 4);
    tready_cur = 1'b1;
    idle(20);
    step('0, 1'b0, '0, 1'b1);
    check("clr_flag",  err_overflow, 1'b0);
    check("clr_drops", drop_cnt, 0);

    // Max packet length: ten reads, ten returns.
    step(4'b1111, 1'b0, '0, 1'b0);
    step(4'b1111, 1'b0, '0, 1'b0);
    step(4'b0011, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) beat('0);
    idle(4);

    // Underflow: a beat with nothing outstanding.
    beat('0);
    check("udf_flag",  err_underflow, 1'b1);
    check("udf_tlast", m_axis_tlast, 1'b1);
    idle(2);
    step('0, 1'b0, '0, 1'b1);

    // Counter saturation.
    for (int i = 0; i < 16385; i++) step(4'b1111, 1'b0, '0, 1'b0);
    check("sat_flag",  err_cnt_sat, 1'b1);
    check("sat_value", outstanding, 16'hFFFF);
    do_reset();

    // Reset in the middle of a drain.
    tready_cur = 1'b0;
    step(4'b1111, 1'b0, '0, 1'b0);
    step(4'b1111, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) beat('0);
    tready_cur = 1'b1;
    idle(2);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [SL-1:0] rd;
      for (int s = 0; s < SL; s++) rd[s] = ($urandom_range(0, 99) < 12);
      tready_cur = ($urandom_range(0, 99) < 70);
      step(rd, ($urandom_range(0, 99) < 50), {$urandom, $urandom},
           ($urandom_range(0, 199) == 0));
    end
    tready_cur = 1'b1;
    idle(40);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rdata_packetizer.md
Name: rdata_packetizer

Overview:
- Sits in the c0_ddr4_clk domain between the DDR4 interface read-data return (rdData/rdDataEn) and the async read-data AXIS FIFO.
- Counts read commands issued by the decoder, buffers returned beats, and frames them into AXIS packets, asserting TLAST on the beat that drains all outstanding reads or on a max-length boundary.
- The read return path cannot stall, so the block provides local buffering and sticky error flags.

Parameters:
- DATA_WIDTH, 512, read data beat width.
- SLOTS, 4, command slots per cycle (width of ddr_read).
- CNT_WIDTH, 16, outstanding-read counter width.
- BUF_DEPTH, 16, internal buffer depth in beats; power of 2, >=4.
- MAX_PKT_BEATS, 64, forced TLAST after this many beats in one packet; >=1.

Ports:
- clk  in  1  c0_ddr4_clk.
- rst  in  1  synchronous, active-high reset; tied to c0_ddr4_rst || ~c0_init_calib_complete.
- ddr_read  in  SLOTS  per-slot read-issue strobes from decoder, same cycle as issue.
- rd_data  in  DATA_WIDTH  returned read beat.
- rd_data_en  in  1  rd_data valid; cannot be back-pressured.
- m_axis_tdata  out  DATA_WIDTH  AXIS data.
- m_axis_tkeep  out  DATA_WIDTH/8  all ones.
- m_axis_tlast  out  1  packet end.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- clr_err  in  1  one-cycle pulse; clears sticky errors and drop_cnt.
- outstanding  out  CNT_WIDTH  current outstanding reads.
- buf_level  out  $clog2(BUF_DEPTH)+1  buffer occupancy.
- err_overflow  out  1  sticky: beat dropped, buffer full.
- err_underflow  out  1  sticky: beat returned with no read outstanding.
- err_cnt_sat  out  1  sticky: outstanding counter saturated.
- drop_cnt  out  16  dropped beats, saturating.

Behaviour:
- Reset: all outputs 0 except m_axis_tkeep (all ones). Counters and buffer are emptied. Reset mid-packet discards buffered beats; there is no partial-TLAST recovery.
- Per cycle: n_iss = popcount(ddr_read) (0..SLOTS), avail = outstanding + n_iss, computed at CNT_WIDTH+3 bits.
- Beat accept (rd_data_en=1):
  - If avail==0: set err_underflow, keep the beat, tag tlast=1, outstanding stays 0.
  - Otherwise: outstanding_next = avail-1, saturated.
  - A read issued in the same cycle as a return counts before the decrement, so there is no spurious TLAST.
- No beat: outstanding_next = avail, saturated.
- Saturation: if the result is >2^CNT_WIDTH-1, clamp to max and set err_cnt_sat.
- Beat tag: tlast = (avail<=1) || (beat_idx==MAX_PKT_BEATS-1).
  - beat_idx counts beats written into the current packet; it resets to 0 after a tlast beat is written.
  - Dropped beats do not advance beat_idx.
- Buffer: synchronous FWFT, {tlast, data}.
  - Write when rd_data_en && (!full || pop).
  - pop = m_axis_tvalid && m_axis_tready.
  - Full and empty are derived from the registered level.
- Overflow: rd_data_en && full && !pop drops the beat, sets err_overflow, increments drop_cnt. outstanding is still decremented.
- Latency: beat accepted in cycle N appears on m_axis_tvalid in cycle N+1 when the buffer was empty. Sustained 1 beat/cycle with tready=1.
- AXIS rules:
  - tvalid = !empty.
  - tdata and tlast are held stable while tvalid && !tready.
  - tvalid never drops without a pop.
- Simultaneous push and pop: buf_level is unchanged; pointers both advance, wrapping modulo BUF_DEPTH.
- clr_err has priority over a same-cycle error set: errors are cleared that cycle and the next error sets again.

Decomposition:
- Package rdata_pkt_pkg: DATA_WIDTH, KEEP_WIDTH, default CNT_WIDTH, and the {last, data} entry width constant.
- One sub-module: sync_fifo_fwft (parameterised width/depth; level, full, empty outputs; push/pop same-cycle safe).
- popcount, counter, and error logic stay in the top module.

Test Plan:
- Single read: ddr_read=4'b0001, rd_data_en 20 cycles later with data A, tready=1 → one beat A, tlast=1, tvalid at +1 cycle; outstanding returns to 0.
- Burst: ddr_read=4'b1111 in one cycle, then 4 beats back-to-back → tlast only on 4th beat; outstanding goes 4,3,2,1,0.
- Overlap: 2 reads outstanding, the last return coincides with a new ddr_read=4'b0001 → no tlast on that beat; tlast on the following beat.
- Backpressure/overflow: tready=0, 20 beats returned → buf_level=16, err_overflow=1, drop_cnt=4; after tready=1, 16 beats drain in order; clr_err clears the flag and drop_cnt.
- Max packet: MAX_PKT_BEATS=4, 10 reads outstanding with 10 returns → tlast on beats 4, 8, 10.
- Underflow and reset: rd_data_en with outstanding=0 → err_underflow=1, beat output with tlast=1. rst asserted mid-drain → tvalid=0 next cycle, buf_level=0, outstanding=0.
